// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// FSM state encoding and requester IDs used by mem_arbiter and rr_pick2.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_t;

   localparam logic ID_CPU = 1'b0;
   localparam logic ID_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way picker for the memory arbiter.
// Ports: req[1:0] (bit index = requester ID), last (previous winner),
//   fixed (1: CPU wins ties), win_valid/win_id (chosen requester).
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       fixed,
   output logic       win_valid,
   output logic       win_id
);

   always_comb begin
      win_valid = |req;
      win_id    = ID_CPU;
      case (req)
         2'b01:   win_id = ID_CPU;
         2'b10:   win_id = ID_LDR;
         // Tie: CPU under fixed priority, otherwise whoever did not go last.
         2'b11:   win_id = fixed ? ID_CPU : ~last;
         default: win_id = ID_CPU;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU + loader) for a single shared memory.
// Ports: clk, reset (sync, active-high); per port req/we/addr/wdata in,
//   gnt/done pulses and rdata out; mem_rd/mem_wr/mem_addr/mem_wdata to the
//   memory, mem_rdata from it; busy high outside IDLE.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 6,
   parameter int DW         = 8,
   parameter int MEM_LAT    = 2,
   parameter int FIXED_PRIO = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_done,
   output logic [DW-1:0] ldr_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
   localparam logic FIXED = (FIXED_PRIO != 0);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic          last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          cpu_gnt_q, cpu_gnt_d;
   logic          ldr_gnt_q, ldr_gnt_d;
   logic          cpu_done_q, cpu_done_d;
   logic          ldr_done_q, ldr_done_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
   logic          busy_q, busy_d;

   logic          win_valid;
   logic          win_id;
   logic          sel_we;

   rr_pick2 u_pick (
      .req       ({ldr_req, cpu_req}),
      .last      (last_q),
      .fixed     (FIXED),
      .win_valid (win_valid),
      .win_id    (win_id)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      we_d        = we_q;
      last_d      = last_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_gnt_d   = 1'b0;
      ldr_gnt_d   = 1'b0;
      cpu_done_d  = 1'b0;
      ldr_done_d  = 1'b0;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      sel_we      = (win_id == ID_LDR) ? ldr_we : cpu_we;

      unique case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               owner_d   = win_id;
               we_d      = sel_we;
               addr_d    = (win_id == ID_LDR) ? ldr_addr : cpu_addr;
               wdata_d   = (win_id == ID_LDR) ? ldr_wdata : cpu_wdata;
               cnt_d     = CNT_INIT;
               cpu_gnt_d = (win_id == ID_CPU);
               ldr_gnt_d = (win_id == ID_LDR);
               // Strobes are registered, so they start with the grant.
               mem_rd_d  = ~sel_we;
               mem_wr_d  = sel_we;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  if (owner_q == ID_LDR) ldr_rdata_d = mem_rdata;
                  else                   cpu_rdata_d = mem_rdata;
               end
               cpu_done_d = (owner_q == ID_CPU);
               ldr_done_d = (owner_q == ID_LDR);
               state_d    = ST_DONE;
            end else begin
               cnt_d    = cnt_q - CW'(1);
               mem_rd_d = ~we_q;
               mem_wr_d = we_q;
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         owner_q     <= ID_CPU;
         we_q        <= 1'b0;
         last_q      <= ID_LDR;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_gnt_q   <= 1'b0;
         ldr_gnt_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
         ldr_done_q  <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_gnt_q   <= cpu_gnt_d;
         ldr_gnt_q   <= ldr_gnt_d;
         cpu_done_q  <= cpu_done_d;
         ldr_done_q  <= ldr_done_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign cpu_gnt   = cpu_gnt_q;
   assign ldr_gnt   = ldr_gnt_q;
   assign cpu_done  = cpu_done_q;
   assign ldr_done  = ldr_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;

endmodule
